// File: rtl/search_seq_ctrl_pkg.sv
// Shared types and constants for the search sequence controller.
package search_seq_ctrl_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_SCAN  = 3'd2,
        ST_SHOW  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // Error codes reported on err.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Shortest string length worth searching (one full pattern).
    localparam int MIN_LEN = 4;

    // Datapath control flags that depend only on the state being entered.
    typedef struct packed {
        logic ready;
        logic roll_back;
        logic busy;
        logic done;
    } ctrl_t;

    // Control flags to register alongside a transition into state s.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_ARM: begin
                c.ready = 1'b1;
                c.busy  = 1'b1;
            end
            ST_SCAN: begin
                c.ready     = 1'b1;
                c.roll_back = 1'b1;
                c.busy      = 1'b1;
            end
            ST_SHOW: begin
                c.ready     = 1'b1;
                c.roll_back = 1'b1;
                c.done      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // True when a requested length fits between MIN_LEN and the string width.
    function automatic logic len_valid(input logic [7:0] len, input int max_bits);
        int l;
        l = int'({24'd0, len});
        return (l >= MIN_LEN) && (l <= max_bits);
    endfunction

endpackage

// File: rtl/search_seq_ctrl_tick.sv
// Display-advance tick generator: one-clk pulse every TICK_DIV enabled clks.
// The count is held at zero while disabled, so each enable run starts fresh.
module disp_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic pulse
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    // Count 0..TICK_DIV-1 while enabled and pulse in the clk after the wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
            pulse   <= 1'b0;
        end else if (!enable) begin
            cnt_reg <= '0;
            pulse   <= 1'b0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
            pulse   <= 1'b1;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
            pulse   <= 1'b0;
        end
    end

endmodule

// File: rtl/search_seq_ctrl.sv
// Search sequence controller: arms and runs the string-search datapath,
// times out a stuck scan, and paces the result display.
module search_seq_ctrl
    import search_seq_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX_SCAN = 64,
    parameter int STR_BITS = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       clear,
    input  logic [7:0] str_len,
    input  logic [3:0] pattern,
    input  logic       scan_done,
    input  logic [5:0] match_cnt_in,
    output logic       ready,
    output logic       roll_back,
    output logic [3:0] in_comp,
    output logic [7:0] len_out,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic [5:0] match_cnt,
    output logic       disp_tick
);
    localparam logic [6:0] SCAN_LAST = 7'(MAX_SCAN - 1);

    state_t     state_reg;
    ctrl_t      ctrl_reg;
    logic [6:0] scan_cnt_reg;
    logic       start_ok;
    logic       stay_show;
    logic       tick_en;

    assign start_ok  = len_valid(str_len, STR_BITS);
    // Ticks only run while SHOW persists into the next clk, so no pulse leaks past exit.
    assign stay_show = (state_reg == ST_SHOW) && !clear && !start;
    assign tick_en   = stay_show && (match_cnt != 6'd0);

    assign ready     = ctrl_reg.ready;
    assign roll_back = ctrl_reg.roll_back;
    assign busy      = ctrl_reg.busy;
    assign done      = ctrl_reg.done;

    // Single-process FSM; every output is registered together with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            ctrl_reg     <= '0;
            scan_cnt_reg <= '0;
            in_comp      <= '0;
            len_out      <= '0;
            err          <= ERR_NONE;
            match_cnt    <= '0;
        end else if (clear) begin
            state_reg    <= ST_IDLE;
            ctrl_reg     <= state_ctrl(ST_IDLE);
            scan_cnt_reg <= '0;
            err          <= ERR_NONE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_SHOW: begin
                    if (start) begin
                        if (start_ok) begin
                            state_reg <= ST_ARM;
                            ctrl_reg  <= state_ctrl(ST_ARM);
                            in_comp   <= pattern;
                            len_out   <= str_len;
                        end else begin
                            state_reg <= ST_ERROR;
                            ctrl_reg  <= state_ctrl(ST_ERROR);
                            err       <= ERR_BAD_LEN;
                        end
                    end
                end
                ST_ARM: begin
                    state_reg    <= ST_SCAN;
                    ctrl_reg     <= state_ctrl(ST_SCAN);
                    scan_cnt_reg <= '0;
                end
                ST_SCAN: begin
                    if (scan_done) begin
                        state_reg    <= ST_SHOW;
                        ctrl_reg     <= state_ctrl(ST_SHOW);
                        match_cnt    <= match_cnt_in;
                        scan_cnt_reg <= '0;
                    end else if (scan_cnt_reg == SCAN_LAST) begin
                        state_reg    <= ST_ERROR;
                        ctrl_reg     <= state_ctrl(ST_ERROR);
                        err          <= ERR_TIMEOUT;
                        scan_cnt_reg <= '0;
                    end else begin
                        scan_cnt_reg <= scan_cnt_reg + 7'd1;
                    end
                end
                ST_ERROR: begin
                    state_reg <= ST_ERROR;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ctrl_reg  <= state_ctrl(ST_IDLE);
                end
            endcase
        end
    end

    disp_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .enable(tick_en),
        .pulse (disp_tick)
    );

endmodule

// File: doc/search_seq_ctrl.md
SEARCH_SEQ_CTRL -- requirements
Module: search_seq_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clk cycles between display-advance ticks.
REQ-002 Parameter MAX_SCAN, default 64, clk cycles allowed in SCAN before timeout.
REQ-003 Parameter STR_BITS, default 40, width of the searched string.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  request a new search; level-sampled each clk.
REQ-007 clear  in  1  abort or finish; returns the block to IDLE.
REQ-008 str_len  in  8  valid string length in bits.
REQ-009 pattern  in  4  4-bit search pattern.
REQ-010 scan_done  in  1  datapath scan-complete flag.
REQ-011 match_cnt_in  in  6  datapath match write index.
REQ-012 ready  out  1  datapath enable; low holds the datapath cleared.
REQ-013 roll_back  out  1  datapath run; low holds the datapath cleared.
REQ-014 in_comp  out  4  pattern latched for the datapath.
REQ-015 len_out  out  8  length latched for the datapath.
REQ-016 busy  out  1  high in ARM and SCAN.
REQ-017 done  out  1  high in SHOW.
REQ-018 err  out  2  error code: 0 none, 1 bad length, 2 scan timeout.
REQ-019 match_cnt  out  6  match count captured on entry to SHOW.
REQ-020 disp_tick  out  1  one-clk pulse that advances the display read index.

Function
REQ-021 FSM states SHALL be IDLE, ARM, SCAN, SHOW and ERROR, with one registered state.
REQ-022 IDLE: ready=0, roll_back=0; start with 4<=str_len<=STR_BITS -> latch pattern/str_len into in_comp/len_out, go ARM; start with any other length -> ERROR, err=1.
REQ-023 ARM: exactly one clk with ready=1 and roll_back=0, so the datapath is still clearing; then go SCAN unconditionally.
REQ-024 SCAN: ready=1, roll_back=1; the 7-bit scan counter increments each clk from 0.
REQ-025 SCAN exit: scan_done=1 -> SHOW and capture match_cnt_in into match_cnt in the same edge; counter reaching MAX_SCAN-1 without scan_done -> ERROR, err=2.
REQ-026 scan_done SHALL be ignored outside SCAN.
REQ-027 SHOW: ready=1, roll_back=1, done=1; the tick counter counts 0..TICK_DIV-1 and disp_tick=1 for the single clk in which it wraps to 0; the counter restarts at 0 on SHOW entry.
REQ-028 SHOW with match_cnt=0: disp_tick SHALL stay 0.
REQ-029 SHOW with start=1 and a valid length: re-latch inputs and go ARM; an invalid length -> ERROR, err=1.
REQ-030 ERROR: ready=0, roll_back=0; err holds until clear; start is ignored.
REQ-031 clear=1 in any state -> IDLE next clk, err=0; clear takes priority over a simultaneous start or scan_done.
REQ-032 in_comp and len_out SHALL change only on an accepted start.
REQ-033 All outputs SHALL be registered; the datapath samples them on the falling edge, so a half-cycle setup is guaranteed.

Reset
REQ-034 Asserting reset SHALL force IDLE immediately, independent of clk.
REQ-035 During reset: all outputs 0, and the scan and tick counters 0.
REQ-036 Reset asserted mid-SCAN or mid-SHOW SHALL drop ready/roll_back at once, clearing the datapath.

Structure
REQ-037 A shared package SHALL hold the state enum, the err code constants, and MIN_LEN=4.
REQ-038 The tick generator SHALL be a sub-module, disp_tick_gen (enable, TICK_DIV parameter, pulse output).

Verification
REQ-039 Bench with TICK_DIV=8: reset low, then high -> all outputs 0, state IDLE.
REQ-040 start with str_len=40, pattern=4'hA; scan_done after 37 SCAN clks with match_cnt_in=3 -> ARM 1 clk, then done=1, match_cnt=3, disp_tick every 8 clks.
REQ-041 start with str_len=3 -> err=1, ready=0; clear -> err=0, IDLE.
REQ-042 start with scan_done never asserted -> err=2 after 64 SCAN clks, roll_back=0.
REQ-043 In SHOW, assert start and clear in the same clk -> IDLE, in_comp unchanged; reset asserted mid-SCAN -> ready=0 with no clk edge.
REQ-044 Complete a search with match_cnt_in=0 -> done=1, disp_tick never pulses; start again from SHOW -> ARM with the new pattern latched.
